// File: rtl/fetch_unit.sv
// Fetch stage with static predict-taken branch/JAL redirect from Decode,
// mispredict recovery from Execute, and the F/D pipeline register.
module fetch_unit (
  input  logic        clk,
  input  logic        nreset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        branch_D,
  input  logic        jump_D,
  input  logic [31:0] ImmExt_D,
  input  logic        mispredict_E,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        valid_D,
  output logic        branched_flag_F
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pcplus4_d;
  logic        r_valid_d;
  logic        r_branched;
  logic [31:0] r_recover_pc;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_pc_d_plus4;

  // A redirect fires once per instruction in D; the flag blocks a repeat
  // while D is held, and stalls or an Execute mispredict defer/suppress it.
  always_comb begin
    w_redirect   = r_valid_d & (branch_D | jump_D) & ~r_branched
                   & ~StallF & ~mispredict_E;
    w_target     = r_pc_d + ImmExt_D;
    w_pc_f_plus4 = r_pc_f + 32'd4;
    w_pc_d_plus4 = r_pc_d + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_pc_f       <= '0;
      r_instr_d    <= NOP;
      r_pc_d       <= '0;
      r_pcplus4_d  <= '0;
      r_valid_d    <= 1'b0;
      r_branched   <= 1'b0;
      r_recover_pc <= '0;
    end else begin
      if (mispredict_E)     r_pc_f <= r_recover_pc;
      else if (w_redirect)  r_pc_f <= w_target;
      else if (!StallF)     r_pc_f <= w_pc_f_plus4;

      // Only conditional branches can be wrong; JAL leaves the recovery PC alone.
      if (w_redirect && branch_D) r_recover_pc <= w_pc_d_plus4;

      if (w_redirect)                              r_branched <= 1'b1;
      else if (mispredict_E || FlushD || !StallD)  r_branched <= 1'b0;

      if (FlushD || mispredict_E) begin
        r_instr_d <= NOP;
        r_valid_d <= 1'b0;
      end else if (!StallD) begin
        r_instr_d   <= Instr_F;
        r_pc_d      <= r_pc_f;
        r_pcplus4_d <= w_pc_f_plus4;
        r_valid_d   <= 1'b1;
      end
    end
  end

  always_comb begin
    PC_F            = r_pc_f;
    Instr_D         = r_instr_d;
    PC_D            = r_pc_d;
    PCPlus4_D       = r_pcplus4_d;
    valid_D         = r_valid_d;
    branched_flag_F = r_branched;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes hand-derived per-edge
// expectations; a monitor checks them one step after each rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic        branch_D = 1'b0, jump_D = 1'b0, mispredict_E = 1'b0;
  logic [31:0] ImmExt_D = '0;
  logic [31:0] Instr_F;
  logic [31:0] PC_F, Instr_D, PC_D, PCPlus4_D;
  logic        valid_D, branched_flag_F;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcp4_d;
    logic        valid;
    logic        flag;
    int          id;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_edge = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign Instr_F = imem(PC_F);

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .nreset(nreset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .branch_D(branch_D), .jump_D(jump_D),
    .ImmExt_D(ImmExt_D), .mispredict_E(mispredict_E), .Instr_F(Instr_F),
    .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .valid_D(valid_D), .branched_flag_F(branched_flag_F)
  );

  // Drive one cycle of inputs and record the state expected after the next edge.
  task automatic cyc(input logic nrst, input logic sf, input logic sd,
                     input logic fd, input logic br, input logic jp,
                     input logic misp, input logic [31:0] imm,
                     input logic [31:0] epc, input logic [31:0] eid,
                     input logic [31:0] epcd, input logic [31:0] ep4,
                     input logic ev, input logic ef);
    exp_t e;
    @(negedge clk);
    nreset = nrst; StallF = sf; StallD = sd; FlushD = fd;
    branch_D = br; jump_D = jp; mispredict_E = misp; ImmExt_D = imm;
    n_edge++;
    e.pc_f = epc; e.instr_d = eid; e.pc_d = epcd; e.pcp4_d = ep4;
    e.valid = ev; e.flag = ef; e.id = n_edge;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (PC_F === e.pc_f && Instr_D === e.instr_d && PC_D === e.pc_d &&
            PCPlus4_D === e.pcp4_d && valid_D === e.valid &&
            branched_flag_F === e.flag)
          n_pass++;
        else
          $display("FAIL edge%0d: got PC_F=%h Instr_D=%h PC_D=%h PCPlus4_D=%h valid_D=%b flag=%b; want PC_F=%h Instr_D=%h PC_D=%h PCPlus4_D=%h valid_D=%b flag=%b",
                   e.id, PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, branched_flag_F,
                   e.pc_f, e.instr_d, e.pc_d, e.pcp4_d, e.valid, e.flag);
      end
    end
  end

  initial begin : stim
    // Reset
    cyc(0,0,0,0,0,0,0,'0, 32'h0, NOP, 32'h0, 32'h0, 0,0);
    cyc(0,0,0,0,0,0,0,'0, 32'h0, NOP, 32'h0, 32'h0, 0,0);
    // Sequential fetch
    cyc(1,0,0,0,0,0,0,'0, 32'h04, imem(32'h00), 32'h00, 32'h04, 1,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h08, imem(32'h04), 32'h04, 32'h08, 1,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h0C, imem(32'h08), 32'h08, 32'h0C, 1,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h10, imem(32'h0C), 32'h0C, 32'h10, 1,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h14, imem(32'h10), 32'h10, 32'h14, 1,0);
    // Predicted branch at PC_D=0x10, D held one cycle
    cyc(1,0,1,0,1,0,0,32'h20, 32'h30, imem(32'h10), 32'h10, 32'h14, 1,1);
    cyc(1,0,0,0,1,0,0,32'h20, 32'h34, imem(32'h30), 32'h30, 32'h34, 1,0);
    // Mispredict -> recover to 0x14
    cyc(1,0,0,0,0,0,1,'0, 32'h14, NOP, 32'h30, 32'h34, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h18, imem(32'h14), 32'h14, 32'h18, 1,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h1C, imem(32'h18), 32'h18, 32'h1C, 1,0);
    // Load stall vs branch: two stalled cycles, then redirect
    cyc(1,1,1,0,1,0,0,32'h100, 32'h1C, imem(32'h18), 32'h18, 32'h1C, 1,0);
    cyc(1,1,1,0,1,0,0,32'h100, 32'h1C, imem(32'h18), 32'h18, 32'h1C, 1,0);
    cyc(1,0,1,0,1,0,0,32'h100, 32'h118, imem(32'h18), 32'h18, 32'h1C, 1,1);
    cyc(1,0,0,0,0,0,0,'0, 32'h11C, imem(32'h118), 32'h118, 32'h11C, 1,0);
    cyc(1,0,0,0,0,0,1,'0, 32'h1C, NOP, 32'h118, 32'h11C, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h20, imem(32'h1C), 32'h1C, 32'h20, 1,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h24, imem(32'h20), 32'h20, 32'h24, 1,0);
    for (int k = 1; k <= 8; k++)
      cyc(1,0,0,0,0,0,0,'0, 32'h24 + 32'(4*k), imem(32'h20 + 32'(4*k)),
          32'h20 + 32'(4*k), 32'h24 + 32'(4*k), 1,0);
    // JAL at PC_D=0x40, offset -16; recovery PC must stay 0x1C
    cyc(1,0,1,0,0,1,0,32'hFFFF_FFF0, 32'h30, imem(32'h40), 32'h40, 32'h44, 1,1);
    cyc(1,0,0,0,0,0,1,'0, 32'h1C, NOP, 32'h40, 32'h44, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h20, imem(32'h1C), 32'h1C, 32'h20, 1,0);
    // Mispredict with branch in D: prediction suppressed
    cyc(1,0,0,0,1,0,1,32'h100, 32'h1C, NOP, 32'h1C, 32'h20, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h20, imem(32'h1C), 32'h1C, 32'h20, 1,0);
    cyc(1,0,0,0,0,0,1,'0, 32'h1C, NOP, 32'h1C, 32'h20, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h20, imem(32'h1C), 32'h1C, 32'h20, 1,0);
    // FlushD bubble
    cyc(1,0,0,1,0,0,0,'0, 32'h24, NOP, 32'h1C, 32'h20, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h28, imem(32'h24), 32'h24, 32'h28, 1,0);
    // Reset in the redirect cycle; recovery PC must read back as 0
    cyc(0,0,0,0,1,0,0,32'h40, 32'h0, NOP, 32'h0, 32'h0, 0,0);
    cyc(1,0,0,0,0,0,1,'0, 32'h0, NOP, 32'h0, 32'h0, 0,0);
    cyc(1,0,0,0,0,0,0,'0, 32'h04, imem(32'h00), 32'h00, 32'h04, 1,0);
    // Redirect to 0xFFFFFFFC, then PC+4 wraps to 0
    cyc(1,0,1,0,1,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC, imem(32'h00), 32'h00, 32'h04, 1,1);
    cyc(1,0,0,0,0,0,0,'0, 32'h0, imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1,0);

    @(negedge clk);
    branch_D = 0; jump_D = 0; mispredict_E = 0; StallF = 0; StallD = 0; FlushD = 0;
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
